// File: rtl/solution_assembler_if.sv
`default_nettype none
// ============================================================================
// solution_assembler_if
// ----------------------------------------------------------------------------
// Bundles the solver-side capture signals and the UART TX byte handshake
// of the solution assembler.
//   valid_in       : one-cycle strobe, solution/n/m are valid
//   solution       : solved grid, solution[r][c] = cell at row r, column c
//   n, m           : row / column count (4 bits each)
//   transmit_busy  : UART TX busy, do not issue a byte
//   transmit_ready : one-cycle pulse, byte_out is valid
//   byte_out       : byte to transmit
// Modports: master = producer/UART side, slave = the assembler.
// Revision: 1.0 - initial release
// ============================================================================
interface solution_assembler_if #(
  parameter int MAX_DIM = 11
);
  logic                              valid_in;
  logic                              transmit_busy;
  logic [MAX_DIM-1:0][MAX_DIM-1:0]   solution;
  logic [3:0]                        n;
  logic [3:0]                        m;
  logic                              transmit_ready;
  logic [7:0]                        byte_out;

  modport master (
    output valid_in, transmit_busy, solution, n, m,
    input  transmit_ready, byte_out
  );

  modport slave (
    input  valid_in, transmit_busy, solution, n, m,
    output transmit_ready, byte_out
  );
endinterface
`default_nettype wire

// File: rtl/solution_assembler.sv
`default_nettype none
// ============================================================================
// solution_assembler
// ----------------------------------------------------------------------------
// Output-side serializer of the nonogram solver. Captures a solved grid on
// valid_in and emits the frame
//   E0, {n,m}, {5'b0,row[10:8]}, row[7:0] (per row), FF
// one byte per transmit_ready pulse, pacing itself on transmit_busy.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (aborts any stream in flight)
//   bus  : solution_assembler_if.slave (capture inputs + UART handshake)
// Revision: 1.0 - initial release
// ============================================================================
module solution_assembler #(
  parameter int MAX_DIM = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  solution_assembler_if.slave  bus
);
  localparam logic [3:0] DIM_MAX    = 4'(MAX_DIM);
  localparam logic [7:0] START_MARK = 8'hE0;
  localparam logic [7:0] END_MARK   = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [MAX_DIM-1:0][MAX_DIM-1:0] grid;
  logic [3:0]         n_c;
  logic [3:0]         m_c;
  logic [4:0]         byte_idx;
  logic [7:0]         byte_q;

  logic [3:0]         n_clamp;
  logic [3:0]         m_clamp;
  logic [MAX_DIM-1:0] col_mask;
  logic [4:0]         last_idx;
  logic [4:0]         row_off;
  logic [3:0]         row_sel;
  logic [15:0]        row_bits;
  logic [7:0]         cur_byte;
  logic               ready;

  // Clamp dimensions and build the column mask at capture time so the
  // stored grid already has unused columns zeroed.
  always_comb begin
    n_clamp = (bus.n > DIM_MAX) ? DIM_MAX : bus.n;
    m_clamp = (bus.m > DIM_MAX) ? DIM_MAX : bus.m;
    col_mask = '0;
    for (int c = 0; c < MAX_DIM; c++) begin
      col_mask[c] = (4'(c) < m_clamp);
    end
  end

  // Byte index 0 = start marker, 1 = dimensions, 2..2N+1 = row pairs,
  // 2N+2 = end marker.
  always_comb begin
    last_idx = 5'd2 + {n_c, 1'b0};
    row_off  = byte_idx - 5'd2;
    row_sel  = row_off[4:1];
    row_bits = 16'(grid[row_sel]);
    if (byte_idx == 5'd0) begin
      cur_byte = START_MARK;
    end else if (byte_idx == 5'd1) begin
      cur_byte = {n_c, m_c};
    end else if (byte_idx >= last_idx) begin
      cur_byte = END_MARK;
    end else if (!row_off[0]) begin
      cur_byte = row_bits[15:8];
    end else begin
      cur_byte = row_bits[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      grid     <= '0;
      n_c      <= '0;
      m_c      <= '0;
      byte_idx <= '0;
      byte_q   <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (bus.valid_in) begin
            n_c <= n_clamp;
            m_c <= m_clamp;
            for (int r = 0; r < MAX_DIM; r++) begin
              grid[r] <= bus.solution[r] & col_mask;
            end
          end
        end
        S_LOAD: byte_idx <= '0;
        // Latch the byte on the way into SEND so it stays put until the
        // next pulse.
        S_WAIT: if (!bus.transmit_busy) byte_q <= cur_byte;
        S_GAP:  if (byte_idx != last_idx) byte_idx <= byte_idx + 5'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      S_IDLE: if (bus.valid_in) state_next = S_LOAD;
      S_LOAD: state_next = S_WAIT;
      S_WAIT: if (!bus.transmit_busy) state_next = S_SEND;
      S_SEND: begin
        ready      = 1'b1;
        state_next = S_GAP;
      end
      S_GAP:  state_next = (byte_idx == last_idx) ? S_IDLE : S_WAIT;
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.transmit_ready = ready;
  assign bus.byte_out       = byte_q;
endmodule
`default_nettype wire

// File: tb/tb_solution_assembler.sv
`default_nettype none
// ============================================================================
// tb_solution_assembler
// ----------------------------------------------------------------------------
// Self-checking bench: directed and random frames compared against a
// cell-level frame model, plus latency, spacing, stall, abort and
// back-to-back checks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_solution_assembler;
  typedef logic [10:0][10:0] grid_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  solution_assembler_if #(.MAX_DIM(11)) bus ();

  solution_assembler #(.MAX_DIM(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int valid_cyc = 0;
  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.transmit_ready) begin
      got_q.push_back(bus.byte_out);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Frame model built cell by cell from the frame rules; appends to exp_q.
  function automatic void model(input grid_t sol, input int nn, input int mm);
    int nc, mc, v;
    nc = (nn > 11) ? 11 : nn;
    mc = (mm > 11) ? 11 : mm;
    exp_q.push_back(8'hE0);
    exp_q.push_back(8'(nc * 16 + mc));
    for (int r = 0; r < nc; r++) begin
      v = 0;
      for (int c = 0; c < mc; c++) if (sol[r][c]) v += (1 << c);
      exp_q.push_back(8'(v / 256));
      exp_q.push_back(8'(v % 256));
    end
    exp_q.push_back(8'hFF);
  endfunction

  function automatic grid_t rand_grid();
    grid_t g;
    for (int r = 0; r < 11; r++) g[r] = 11'($urandom);
    return g;
  endfunction

  task automatic clear_all();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic pulse_valid(input grid_t sol, input logic [3:0] nn, input logic [3:0] mm);
    bus.solution = sol;
    bus.n        = nn;
    bus.m        = mm;
    bus.valid_in = 1'b1;
    valid_cyc    = cyc + 1;
    tick();
    bus.valid_in = 1'b0;
    bus.solution = rand_grid();
    bus.n        = 4'($urandom);
    bus.m        = 4'($urandom);
  endtask

  task automatic wait_count(input int cnt, input int budget, input bit rb);
    int k;
    k = 0;
    while (got_q.size() < cnt && k < budget) begin
      if (rb) bus.transmit_busy = ($urandom_range(0, 2) == 0);
      tick();
      k++;
    end
    if (got_q.size() < cnt) check("timeout", got_q.size(), cnt);
  endtask

  task automatic settle();
    bus.transmit_busy = 1'b0;
    repeat (10) tick();
  endtask

  task automatic compare(input string tag, input bit timing);
    int lim;
    check({tag, "_len"}, got_q.size(), exp_q.size());
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++)
      check($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    if (timing && lim > 0) begin
      check({tag, "_lat"}, got_cyc[0] - valid_cyc, 2);
      for (int i = 1; i < lim; i++)
        check($sformatf("%s_gap%0d", tag, i), got_cyc[i] - got_cyc[i-1], 3);
    end
  endtask

  task automatic run_frame(input string tag, input grid_t sol, input logic [3:0] nn,
                           input logic [3:0] mm, input bit rb);
    clear_all();
    model(sol, nn, mm);
    pulse_valid(sol, nn, mm);
    wait_count(exp_q.size(), 600, rb);
    settle();
    compare(tag, !rb);
    check({tag, "_hold"}, bus.byte_out, 8'hFF);
    check({tag, "_rdy_low"}, bus.transmit_ready, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  grid_t g4, ones, g1, ga, gb;
  int asz;

  initial begin
    rst = 1'b1;
    bus.valid_in = 1'b0;
    bus.transmit_busy = 1'b0;
    bus.solution = '0;
    bus.n = '0;
    bus.m = '0;
    g4 = '0;
    g4[0] = 11'b1001; g4[1] = 11'b0110; g4[2] = 11'b0110; g4[3] = 11'b1001;
    ones = '1;
    g1 = '0;
    g1[0] = 11'b1;

    repeat (3) tick();
    check("rst_ready", bus.transmit_ready, 1'b0);
    check("rst_byte", bus.byte_out, 8'h00);
    rst = 1'b0;
    tick();

    // Busy held high: nothing must come out.
    clear_all();
    bus.transmit_busy = 1'b1;
    pulse_valid(g4, 4'd4, 4'd4);
    repeat (40) tick();
    check("busy_pulses", got_q.size(), 0);
    check("busy_byte", bus.byte_out, 8'h00);
    bus.transmit_busy = 1'b0;
    do_reset();

    run_frame("diag4", g4, 4'd4, 4'd4, 1'b0);
    run_frame("full11", ones, 4'd11, 4'd11, 1'b0);
    run_frame("mask23", ones, 4'd2, 4'd3, 1'b0);
    run_frame("n0", ones, 4'd0, 4'd5, 1'b0);
    run_frame("clamp", rand_grid(), 4'd15, 4'd13, 1'b0);

    for (int t = 0; t < 6; t++) begin
      run_frame($sformatf("rnd%0d", t), rand_grid(), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), t[0]);
    end

    // Stall after the third byte with an ignored mid-frame valid_in.
    clear_all();
    model(g4, 4, 4);
    pulse_valid(g4, 4'd4, 4'd4);
    wait_count(3, 100, 1'b0);
    bus.transmit_busy = 1'b1;
    repeat (5) tick();
    pulse_valid(ones, 4'd2, 4'd3);
    repeat (14) tick();
    bus.transmit_busy = 1'b0;
    wait_count(11, 200, 1'b0);
    settle();
    compare("pause", 1'b0);
    if (got_cyc.size() >= 4) check("pause_gap", (got_cyc[3] - got_cyc[2]) >= 20, 1);

    // Reset mid-frame aborts; new frame afterwards.
    clear_all();
    pulse_valid(rand_grid(), 4'd11, 4'd11);
    wait_count(4, 100, 1'b0);
    rst = 1'b1;
    repeat (2) tick();
    check("abort_ready", bus.transmit_ready, 1'b0);
    check("abort_byte", bus.byte_out, 8'h00);
    rst = 1'b0;
    got_q.delete();
    got_cyc.delete();
    repeat (10) tick();
    check("abort_quiet", got_q.size(), 0);
    run_frame("post_rst", g1, 4'd1, 4'd1, 1'b0);

    // Back-to-back: second valid_in on the first IDLE cycle.
    clear_all();
    ga = rand_grid();
    gb = rand_grid();
    model(ga, 3, 7);
    asz = exp_q.size();
    pulse_valid(ga, 4'd3, 4'd7);
    wait_count(asz, 100, 1'b0);
    tick();
    tick();
    model(gb, 2, 11);
    pulse_valid(gb, 4'd2, 4'd11);
    wait_count(exp_q.size(), 100, 1'b0);
    settle();
    compare("b2b", 1'b0);
    if (got_cyc.size() > asz) check("b2b_turn", got_cyc[asz] - got_cyc[asz-1], 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
